// File: rtl/alu_pkg.sv
// Shared types for the ALU operand sequencer: operand/result widths and the
// packed records carried through the operation and result FIFOs.
package alu_pkg;

   localparam int ALU_OP_W  = 3;
   localparam int ALU_RES_W = 4;

   typedef struct packed {
      logic [ALU_OP_W-1:0] a;
      logic [ALU_OP_W-1:0] b;
      logic                sel;
   } alu_op_t;

   typedef struct packed {
      logic [ALU_RES_W-1:0] result;
      logic                 sel;
   } alu_res_t;

   function automatic alu_op_t alu_op_pack(input logic [ALU_OP_W-1:0] a,
                                           input logic [ALU_OP_W-1:0] b,
                                           input logic                sel);
      alu_op_t op;
      op.a   = a;
      op.b   = b;
      op.sel = sel;
      return op;
   endfunction

   function automatic alu_res_t alu_res_pack(input logic [ALU_RES_W-1:0] result,
                                             input logic                 sel);
      alu_res_t res;
      res.result = result;
      res.sel    = sel;
      return res;
   endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous FIFO with occupancy count. Depth need not be a power of two:
// pointers wrap explicitly at DEPTH-1. Storage is cleared on reset so the
// head output reads zero while empty after reset.
module alu_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [PTR_W-1:0] LAST_PTR_C = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT_C = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             wr_s;
   logic             rd_s;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == LAST_PTR_C) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Qualify requests against occupancy so misuse can never corrupt pointers
   always_comb begin
      wr_s = wr_en && (count_r != FULL_CNT_C);
      rd_s = rd_en && (count_r != {CNT_W{1'b0}});
   end

   // Storage write and pointer advance
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         if (wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r        <= next_ptr(wr_ptr_r);
         end
         if (rd_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end
      end
   end

   // Occupancy counter; simultaneous push and pop leave it unchanged
   always_ff @(posedge clock) begin
      if (reset) begin
         count_r <= {CNT_W{1'b0}};
      end else begin
         case ({wr_s, rd_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign rd_data = mem_r[rd_ptr_r];
   assign count   = count_r;

endmodule

// File: rtl/alu_op_sequencer.sv
// Operand sequencer and result collector around a 1-cycle registered ALU.
// Ops are buffered, issued one per edge when the result buffer has credit
// for everything already in flight, and results are captured two edges
// after issue and returned in order.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int IN_DEPTH  = 4,
   parameter int OUT_DEPTH = 3
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ALU_OP_W-1:0]       in_a,
   input  logic [ALU_OP_W-1:0]       in_b,
   input  logic                      in_sel,
   output logic [ALU_OP_W-1:0]       alu_a,
   output logic [ALU_OP_W-1:0]       alu_b,
   output logic                      alu_sel,
   input  logic [ALU_RES_W-1:0]      alu_result,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ALU_RES_W-1:0]      out_result,
   output logic                      out_sel,
   output logic [$clog2(IN_DEPTH):0] in_count
);

   localparam int IN_CNT_W  = $clog2(IN_DEPTH) + 1;
   localparam int OUT_CNT_W = $clog2(OUT_DEPTH) + 1;
   localparam int CRED_W    = OUT_CNT_W + 1;
   localparam logic [IN_CNT_W-1:0] IN_FULL_C = IN_CNT_W'(IN_DEPTH);
   localparam logic [CRED_W-1:0]   OUT_LIM_C = CRED_W'(OUT_DEPTH);

   alu_op_t              in_wr_data_s;
   alu_op_t              in_head_s;
   alu_res_t             out_wr_data_s;
   alu_res_t             out_head_s;
   logic                 in_wr_s;
   logic                 issue_s;
   logic                 pop_s;
   logic [OUT_CNT_W-1:0] out_count_s;
   logic [CRED_W-1:0]    credit_used_s;
   logic [CRED_W-1:0]    credit_lim_s;
   logic                 s1_r;
   logic                 s1_sel_r;
   logic                 s2_r;
   logic                 s2_sel_r;

   assign in_ready     = (in_count != IN_FULL_C);
   assign in_wr_s      = in_valid && in_ready;
   assign in_wr_data_s = alu_op_pack(in_a, in_b, in_sel);
   assign out_valid    = (out_count_s != {OUT_CNT_W{1'b0}});
   assign pop_s        = out_valid && out_ready;
   assign out_wr_data_s = alu_res_pack(alu_result, s2_sel_r);
   assign out_result   = out_head_s.result;
   assign out_sel      = out_head_s.sel;

   alu_sync_fifo #(
      .WIDTH ($bits(alu_op_t)),
      .DEPTH (IN_DEPTH)
   ) u_in_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (in_wr_s),
      .wr_data (in_wr_data_s),
      .rd_en   (issue_s),
      .rd_data (in_head_s),
      .count   (in_count)
   );

   alu_sync_fifo #(
      .WIDTH ($bits(alu_res_t)),
      .DEPTH (OUT_DEPTH)
   ) u_out_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (s2_r),
      .wr_data (out_wr_data_s),
      .rd_en   (pop_s),
      .rd_data (out_head_s),
      .count   (out_count_s)
   );

   // Issue only if buffered plus in-flight results still fit after this edge's pop
   always_comb begin
      credit_used_s = {1'b0, out_count_s}
                    + {{OUT_CNT_W{1'b0}}, s1_r}
                    + {{OUT_CNT_W{1'b0}}, s2_r};
      credit_lim_s  = OUT_LIM_C + {{OUT_CNT_W{1'b0}}, pop_s};
      if ((in_count != {IN_CNT_W{1'b0}}) && (credit_used_s < credit_lim_s)) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end
   end

   // Operand registers: load on issue, hold last issued value while idle
   always_ff @(posedge clock) begin
      if (reset) begin
         alu_a   <= {ALU_OP_W{1'b0}};
         alu_b   <= {ALU_OP_W{1'b0}};
         alu_sel <= 1'b0;
      end else if (issue_s) begin
         alu_a   <= in_head_s.a;
         alu_b   <= in_head_s.b;
         alu_sel <= in_head_s.sel;
      end else begin
         alu_a   <= alu_a;
         alu_b   <= alu_b;
         alu_sel <= alu_sel;
      end
   end

   // Two-stage busy pipe tracking when the ALU result is worth capturing
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_r     <= 1'b0;
         s1_sel_r <= 1'b0;
         s2_r     <= 1'b0;
         s2_sel_r <= 1'b0;
      end else begin
         s1_r     <= issue_s;
         s1_sel_r <= issue_s ? in_head_s.sel : s1_sel_r;
         s2_r     <= s1_r;
         s2_sel_r <= s1_sel_r;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer. The registered add/sub ALU is
// modelled inline. A queue-based scoreboard predicts every result from the
// arithmetic of each accepted op; directed sequences pin latency, wrap,
// throughput, backpressure and reset behaviour with literal expectations.
module tb_alu_op_sequencer;

   logic       clock = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_a;
   logic [2:0] in_b;
   logic       in_sel;
   logic [2:0] alu_a;
   logic [2:0] alu_b;
   logic       alu_sel;
   logic [3:0] alu_result;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_result;
   logic       out_sel;
   logic [2:0] in_count;

   int n_vec = 0;
   int n_err = 0;

   logic [4:0] exp_q [$];
   logic       prev_hold = 1'b0;
   logic [4:0] prev_out  = 5'd0;

   alu_op_sequencer #(.IN_DEPTH(4), .OUT_DEPTH(3)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_sel     (in_sel),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_result (alu_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_sel    (out_sel),
      .in_count   (in_count)
   );

   always #5 clock = ~clock;

   // Registered add/sub ALU sharing the sequencer reset
   always @(posedge clock) begin
      if (reset) alu_result <= 4'd0;
      else if (alu_sel) alu_result <= {1'b0, alu_a} - {1'b0, alu_b};
      else alu_result <= {1'b0, alu_a} + {1'b0, alu_b};
   end

   function automatic logic [3:0] arith(input int a, input int b, input bit sel);
      int r;
      r = sel ? (a - b) : (a + b);
      r = ((r % 16) + 16) % 16;
      return r[3:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [2:0] a, input logic [2:0] b, input logic sel);
      in_valid = 1'b1; in_a = a; in_b = b; in_sel = sel;
      step();
      in_valid = 1'b0;
   endtask

   task automatic get_result(input string name, input logic [3:0] er, input logic es);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         if (out_valid) begin
            check({name, "_res"}, out_result, er);
            check({name, "_sel"}, out_sel, es);
            got = 1'b1;
         end
         step();
      end
      if (!got) check({name, "_timeout"}, out_valid, 1);
   endtask

   // Scoreboard: every negedge, predict handshakes of the coming edge
   always @(negedge clock) begin
      if (reset) begin
         exp_q.delete();
         prev_hold = 1'b0;
      end else begin
         check("in_ready_vs_count", in_ready, (in_count != 3'd4));
         if (prev_hold) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", {out_result, out_sel}, prev_out);
         end
         if (out_valid) check("result_expected", (exp_q.size() != 0), 1);
         if (out_valid && out_ready && exp_q.size() != 0) begin
            check("order", {out_result, out_sel}, exp_q[0]);
            void'(exp_q.pop_front());
         end
         if (in_valid && in_ready)
            exp_q.push_back({arith(int'(in_a), int'(in_b), in_sel), in_sel});
         prev_hold = out_valid && !out_ready;
         prev_out  = {out_result, out_sel};
      end
   end

   initial begin
      int i;
      int nres;
      int first;
      int last;
      bit ready_drop;

      reset = 1'b1; in_valid = 1'b0; in_a = 3'd0; in_b = 3'd0; in_sel = 1'b0; out_ready = 1'b0;
      step(); step();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_sel", out_sel, 0);
      check("rst_in_count", in_count, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_alu_a", alu_a, 0);
      reset = 1'b0;

      // Single op latency: 3+4 accepted at E, visible after E+3
      send(3'd3, 3'd4, 1'b0);
      check("lat_in_count_E", in_count, 1);
      step();
      check("lat_alu_a", alu_a, 3);
      check("lat_alu_b", alu_b, 4);
      check("lat_alu_sel", alu_sel, 0);
      check("lat_in_count_E1", in_count, 0);
      check("lat_valid_E1", out_valid, 0);
      step();
      check("lat_valid_E2", out_valid, 0);
      step();
      check("lat_valid_E3", out_valid, 1);
      check("lat_result", out_result, 7);
      check("lat_sel", out_sel, 0);
      out_ready = 1'b1;
      step();
      check("lat_drained", out_valid, 0);

      // Subtract wrap and max add
      send(3'd2, 3'd5, 1'b1);
      send(3'd7, 3'd7, 1'b0);
      get_result("sub_wrap", 4'hD, 1'b1);
      get_result("add_max", 4'hE, 1'b0);

      // Back-to-back stream of 8 with out_ready high
      i = 0; nres = 0; first = -1; last = -1; ready_drop = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (i < 8) begin
            in_valid = 1'b1; in_a = i[2:0]; in_b = 3'd7 - i[2:0]; in_sel = i[0];
            if (!in_ready) ready_drop = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid) begin
            if (first < 0) first = c;
            last = c;
            nres++;
         end
         if (in_valid && in_ready) i++;
         step();
      end
      check("stream_accepted", i, 8);
      check("stream_results", nres, 8);
      check("stream_no_bubble", last - first, 7);
      check("stream_ready_held", ready_drop, 0);

      // Backpressure: 8 offered with out_ready low, 7 accepted
      out_ready = 1'b0;
      i = 0;
      for (int c = 0; c < 15; c++) begin
         if (i < 8) begin
            in_valid = 1'b1; in_a = i[2:0]; in_b = 3'd1; in_sel = 1'b0;
         end else begin
            in_valid = 1'b0;
         end
         if (in_valid && in_ready) i++;
         step();
      end
      in_valid = 1'b0;
      check("bp_accepted", i, 7);
      check("bp_in_count", in_count, 4);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_head", out_result, 1);
      out_ready = 1'b1;
      nres = 0;
      for (int c = 0; c < 40; c++) begin
         if (out_valid) nres++;
         step();
      end
      check("bp_released", nres, 7);

      // Reset with ops buffered, in flight and queued
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_a = 3'd1; in_b = 3'd2; in_sel = 1'b0; step();
      in_a = 3'd2; in_b = 3'd3; in_sel = 1'b0; step();
      in_a = 3'd3; in_b = 3'd3; in_sel = 1'b1; step();
      in_a = 3'd6; in_b = 3'd1; in_sel = 1'b1; step();
      in_valid = 1'b0;
      check("pre_rst_valid", out_valid, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_in_count", in_count, 0);
      check("mid_rst_alu_a", alu_a, 0);
      check("mid_rst_alu_b", alu_b, 0);
      check("mid_rst_alu_sel", alu_sel, 0);
      for (int c = 0; c < 5; c++) begin
         step();
         check("post_rst_quiet", out_valid, 0);
      end
      out_ready = 1'b1;
      send(3'd5, 3'd1, 1'b1);
      get_result("post_rst", 4'd4, 1'b1);

      // Random traffic against the scoreboard
      for (int c = 0; c < 10000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_a      = 3'($urandom_range(0, 7));
         in_b      = 3'($urandom_range(0, 7));
         in_sel    = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) step();
      step();
      check("drain_queue", exp_q.size(), 0);
      check("drain_valid", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
